hpm_counter_bank: RTL
=====================

# hpm_counter_bank

Parametrised bank of event counters for the machine-mode CSR file, generalising the single-purpose cycle and instret counters to NUM_COUNTERS channels. Each channel has its own programmable event select, inhibit bit and sticky overflow flag. The bank takes one-cycle event pulses from the control unit and datapath and exposes 32-bit CSR read/write access per half-word. An OR-reduced overflow interrupt feeds the interrupt logic next to mtip, msip and meip.

## Interface
- NUM_COUNTERS, default 4: number of counter channels, legal range 1..29.
- CTR_WIDTH, default 64: counter width, legal range 33..64.
- NUM_EVENTS, default 8: number of event inputs.
- SEL_WIDTH, default $clog2(NUM_EVENTS+1): width of the event-select field.
- IDX_WIDTH, default $clog2(NUM_COUNTERS) (minimum 1): width of the channel index.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; the bank is held in reset while 0.
- events  in  NUM_EVENTS  one-cycle event pulses; bit k is event k+1.
- freeze  in  1  global hold, for debug halt; no channel increments while 1.
- csr_we  in  1  CSR write strobe.
- csr_field  in  2  field select, csr_field_t: FIELD_LO, FIELD_HI, FIELD_EVENT, FIELD_INHIBIT.
- csr_idx  in  IDX_WIDTH  channel index.
- csr_wd  in  32  write data.
- csr_rd  out  32  combinational read data for csr_field/csr_idx.
- ovf_irq  out  1  registered OR of all overflow flags.

## Operation
- Per-channel state: counter cnt[CTR_WIDTH], select sel[SEL_WIDTH], overflow flag of, inhibit bit inh.
- Event stage: events are registered into ev_q every cycle. The registered value is used, not the raw input.
- Event selection: sel=0 never counts. sel=k (1..NUM_EVENTS) counts ev_q[k-1].
  - Several channels may select the same event.
- Increment condition: inc_i = ev_q[sel_i-1] & ~inh_i & ~freeze & (sel_i != 0).
  - inc_i adds exactly 1 per cycle.
- Wrap: cnt all-ones plus increment gives 0 and sets of_i on the same edge.
  - of is sticky and is cleared only by a CSR write.
- CSR read layout:
  - FIELD_LO returns cnt[31:0].
  - FIELD_HI returns cnt[CTR_WIDTH-1:32], zero-extended.
  - FIELD_EVENT returns {1'b0, of, zero padding, sel}, with of at bit 30.
  - FIELD_INHIBIT returns inhibit bits of all channels at bits [NUM_COUNTERS-1:0], ignoring csr_idx.
- CSR write rules:
  - FIELD_LO replaces cnt[31:0].
  - FIELD_HI replaces cnt[CTR_WIDTH-1:32].
  - FIELD_EVENT writes sel from wd[SEL_WIDTH-1:0] and of from wd[30]. The select is WARL: a value > NUM_EVENTS stores 0.
  - FIELD_INHIBIT writes all inhibit bits from wd[NUM_COUNTERS-1:0].
- Out-of-range index: csr_idx >= NUM_COUNTERS reads 0, and writes to LO/HI/EVENT are ignored.
- Collision, counter write vs increment: a LO/HI write wins entirely. That cycle's increment for the channel is dropped, including any carry into the other half.
- Collision, event write vs overflow: overflow wins. of is set if the same-edge increment wraps, regardless of wd[30]. sel still takes wd.
- Inhibit timing: increments at an edge use the inhibit value held before that edge. A write to inhibit affects counting from the following edge.
- Reset values:
  - cnt, sel, of, inh, ev_q all 0.
  - ovf_irq = 0.
  - csr_rd = 0 for every field and index.

## Timing
- Event latency: an event pulse in cycle t is registered at edge t+1. The increment lands at edge t+2, so the new count is readable in cycle t+2.
- Write latency: a CSR write in cycle t is visible on csr_rd in cycle t+1.
- Read latency: csr_rd is combinational from current state; zero latency.
- ovf_irq timing: registered one edge after of changes, so it rises in cycle t+1 after the wrap edge t.
- Reset mid-operation: reset assertion clears all state immediately, without waiting for a clock edge. This includes any pending ev_q pulses, which are lost.
- Reset release: first increments are possible from the second edge after release.
- Freeze: freeze in cycle t blocks the increment at edge t+1. ev_q keeps sampling, so a pulse pending during freeze is lost.

## Structure
- Package enums:
  - csr_field_t: 2-bit enum FIELD_LO=0, FIELD_HI=1, FIELD_EVENT=2, FIELD_INHIBIT=3.
  - Constant for the EVENT_OF_BIT position, 30.
- Sub-module hpm_counter: one channel with cnt, sel, of, write decode, increment and wrap. Instantiated NUM_COUNTERS times in a generate loop.
- Top level holds ev_q, the inhibit vector, the read mux and the ovf_irq register.

## Test plan
- Reset: hold reset=0 with events all-ones -> every csr_rd is 0 and ovf_irq=0. Release with sel all 0 -> counters stay 0.
- Basic count: channel 1 sel=3, pulse events[2] in cycle 10 -> FIELD_LO reads 0 in cycle 11 and 1 in cycle 12. 100 back-to-back pulses -> 100.
- Wrap and IRQ: write LO=32'hFFFF_FFFF and HI=32'hFFFF_FFFF (CTR_WIDTH=64), then one event -> cnt=0 and of=1, EVENT reads bit30 set. ovf_irq rises one cycle later. Writing EVENT with wd[30]=0 clears ovf_irq on the following edge.
- Collisions:
  - LO write of 32'h5 in the same cycle as an increment -> reads 5.
  - EVENT write with wd[30]=0 on a wrapping edge -> of=1.
  - sel write of 9 with NUM_EVENTS=8 -> reads sel 0.
- Inhibit and freeze:
  - Inhibit bit 0 set -> channel 0 frozen while channel 1 on the same event counts.
  - freeze=1 for 5 pulses -> no channel changes.
- Async reset mid-count: assert reset between edges while counting -> csr_rd drops to 0 before the next edge, and ev_q pulse lost.

Source files
------------

// File: rtl/hpm_counter_bank_pkg.sv
// Shared types and constants for the hardware performance-monitor counter bank.
package hpm_counter_bank_pkg;

  typedef enum logic [1:0] {
    FIELD_LO      = 2'd0,
    FIELD_HI      = 2'd1,
    FIELD_EVENT   = 2'd2,
    FIELD_INHIBIT = 2'd3
  } csr_field_t;

  localparam int CSR_WIDTH    = 32;
  localparam int EVENT_OF_BIT = 30;

endpackage

// File: rtl/hpm_counter.sv
// One performance counter channel: count register, event select, sticky
// overflow flag, CSR write handling, increment and wrap detection.
module hpm_counter
  import hpm_counter_bank_pkg::*;
#(
  parameter int CTR_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] ev_q,
  input  logic                  inh,
  input  logic                  freeze,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic                  wr_event,
  input  logic [CSR_WIDTH-1:0]  wd,
  output logic [CTR_WIDTH-1:0]  cnt,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  of
);

  logic                 hit;
  logic                 inc;
  logic                 cnt_wr;
  logic                 wrap;
  logic [SEL_WIDTH-1:0] sel_wd;
  logic                 sel_legal;

  // sel == 0 matches no event, so hit stays low for it.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel == SEL_WIDTH'(k + 1)) hit = ev_q[k];
    end
  end

  assign inc       = hit & ~inh & ~freeze;
  assign cnt_wr    = wr_lo | wr_hi;
  // A software write to the count swallows the increment, so it cannot wrap.
  assign wrap      = inc & ~cnt_wr & (&cnt);
  assign sel_wd    = wd[SEL_WIDTH-1:0];
  assign sel_legal = 32'(sel_wd) <= 32'(NUM_EVENTS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sel <= '0;
      of  <= 1'b0;
    end else begin
      if (wr_lo) begin
        cnt[31:0] <= wd;
      end else if (wr_hi) begin
        cnt[CTR_WIDTH-1:32] <= wd[CTR_WIDTH-33:0];
      end else if (inc) begin
        cnt <= cnt + CTR_WIDTH'(1);
      end

      // A wrap on the same edge as a software clear keeps the flag set.
      if (wr_event) begin
        sel <= sel_legal ? sel_wd : '0;
        of  <= wd[EVENT_OF_BIT] | wrap;
      end else if (wrap) begin
        of <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NUM_COUNTERS event counters with half-word CSR access, a shared
// inhibit register and an OR-reduced overflow interrupt.
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int CTR_WIDTH    = 64,
  parameter int NUM_EVENTS   = 8,
  parameter int SEL_WIDTH    = $clog2(NUM_EVENTS + 1),
  parameter int IDX_WIDTH    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  freeze,
  input  logic                  csr_we,
  input  logic [1:0]            csr_field,
  input  logic [IDX_WIDTH-1:0]  csr_idx,
  input  logic [CSR_WIDTH-1:0]  csr_wd,
  output logic [CSR_WIDTH-1:0]  csr_rd,
  output logic                  ovf_irq
);

  csr_field_t              field;
  logic [NUM_EVENTS-1:0]   ev_q;
  logic [NUM_COUNTERS-1:0] inh;
  logic [NUM_COUNTERS-1:0] of_vec;
  logic [NUM_COUNTERS-1:0] wr_lo;
  logic [NUM_COUNTERS-1:0] wr_hi;
  logic [NUM_COUNTERS-1:0] wr_event;
  logic [CTR_WIDTH-1:0]    cnt_arr [NUM_COUNTERS];
  logic [SEL_WIDTH-1:0]    sel_arr [NUM_COUNTERS];

  assign field = csr_field_t'(csr_field);

  // Registered events, inhibit vector and interrupt. Counting at an edge
  // sees the inhibit value held before that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_q    <= '0;
      inh     <= '0;
      ovf_irq <= 1'b0;
    end else begin
      ev_q    <= events;
      ovf_irq <= |of_vec;
      if (csr_we && field == FIELD_INHIBIT) inh <= csr_wd[NUM_COUNTERS-1:0];
    end
  end

  // Indices with no matching channel decode to no strobe, so those writes drop.
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ch
    logic idx_hit;
    assign idx_hit     = csr_we && (csr_idx == IDX_WIDTH'(i));
    assign wr_lo[i]    = idx_hit && field == FIELD_LO;
    assign wr_hi[i]    = idx_hit && field == FIELD_HI;
    assign wr_event[i] = idx_hit && field == FIELD_EVENT;

    hpm_counter #(
      .CTR_WIDTH (CTR_WIDTH),
      .NUM_EVENTS(NUM_EVENTS),
      .SEL_WIDTH (SEL_WIDTH)
    ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .ev_q    (ev_q),
      .inh     (inh[i]),
      .freeze  (freeze),
      .wr_lo   (wr_lo[i]),
      .wr_hi   (wr_hi[i]),
      .wr_event(wr_event[i]),
      .wd      (csr_wd),
      .cnt     (cnt_arr[i]),
      .sel     (sel_arr[i]),
      .of      (of_vec[i])
    );
  end

  always_comb begin
    csr_rd = '0;
    if (field == FIELD_INHIBIT) begin
      csr_rd[NUM_COUNTERS-1:0] = inh;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (csr_idx == IDX_WIDTH'(i)) begin
          case (field)
            FIELD_LO: csr_rd = cnt_arr[i][31:0];
            FIELD_HI: csr_rd = CSR_WIDTH'(cnt_arr[i][CTR_WIDTH-1:32]);
            default: begin
              csr_rd[SEL_WIDTH-1:0]  = sel_arr[i];
              csr_rd[EVENT_OF_BIT]   = of_vec[i];
            end
          endcase
        end
      end
    end
  end

endmodule
